tlp_width_bridge: RTL and testbench
===================================

Name: tlp_width_bridge

Overview:
- Parametrised store-and-forward bridge from a narrow TLP receive stream (IN_W) to a wide TLP stream (OUT_W); generalises the fixed 16b-to-64b path.
- Packs IN_W words into OUT_W beats and buffers whole TLPs in an internal dual-port RAM. A TLP is released downstream only after its last word is written.
- Adds what the fixed bridge lacks: downstream valid/ready backpressure, overflow and abort drop with TLP-granular rewind, optional malformed-TLP discard, and a drop counter.
- Sits between the PCIe core RX interface and the wide TLP decoder.

Parameters:
- IN_W, 16, input word width; OUT_W/IN_W = R must be a power of two, at least 2.
- OUT_W, 64, output beat width.
- ADDR_W, 9, buffer address width; depth is 2^ADDR_W beats.
- BAR_W, 7, BAR hit vector width.
- DROP_MALF, 0, 1 = discard TLPs flagged malformed on the end word.
- LW, log2(R), width of the lane-count field (derived; minimum 1).

Ports:
- clk_125 in 1: the only clock.
- rst in 1: synchronous, active-high reset.
- rx_data_in in IN_W: input word.
- rx_st_in in 1: first word of a TLP.
- rx_end_in in 1: last word of a TLP; may coincide with rx_st_in.
- rx_us_req_in in 1: unsupported request; sampled on the st word.
- rx_malf_tlp_in in 1: malformed flag; sampled on the end word.
- rx_bar_hit_in in BAR_W: BAR hit vector; sampled on the st word.
- rx_data_out out OUT_W: output beat. The first-received word occupies the most significant lane.
- rx_valid_out out 1: beat valid.
- rx_rdy_in in 1: downstream ready.
- rx_st_out out 1: first beat of a TLP.
- rx_end_out out 1: last beat of a TLP.
- rx_lanes_out out LW: number of valid lanes minus 1 on the end beat; R-1 on all other beats.
- rx_us_req_out out 1: held for every beat of the TLP.
- rx_malf_tlp_out out 1: asserted on the end beat only.
- rx_bar_hit_out out BAR_W: held for every beat of the TLP.
- tlp_drop out 1: one-cycle pulse per dropped TLP.
- drop_cnt out 16: saturating count of dropped TLPs.

Behaviour:
- Reset (rst high at a clk_125 edge):
  - all outputs go to 0 and drop_cnt goes to 0;
  - write, commit and read pointers go to 0, and the buffer is empty;
  - the packing counter and the receiving flag are cleared.
- Reset mid-TLP discards all buffered and partially written data. No beat is emitted for that TLP afterwards.
- Packing:
  - rx_st_in clears the lane counter; word k of the TLP goes to lane (k mod R), with lane 0 = bits [OUT_W-1:OUT_W-IN_W];
  - a beat is written when lane R-1 fills or on rx_end_in;
  - unused lanes of a partial end beat are 0;
  - words arriving while not receiving and without rx_st_in are ignored.
- Commit: on the write of the end beat, the commit pointer is set to write addr+1. The read side sees only committed beats.
- Overflow: if a beat write would make write addr+1 equal the read addr:
  - rewind the write addr to the commit pointer;
  - enter DROP and ignore words until rx_end_in;
  - pulse tlp_drop on entry.
- Abort: rx_st_in while already receiving (no end seen) rewinds the write addr to the commit pointer, pulses tlp_drop, and starts the new TLP in the same cycle.
- Malformed discard: with DROP_MALF=1 and rx_malf_tlp_in on the end word, do not commit; rewind and pulse tlp_drop. With DROP_MALF=0 the TLP is committed and malf is forwarded.
- drop_cnt increments on each tlp_drop and saturates at 16'hFFFF.
- Write-side states: IDLE, RECV, DROP.
  - IDLE to RECV on st; IDLE to IDLE on st&end (single-word TLP).
  - RECV to IDLE on end; RECV to DROP on overflow.
  - DROP to IDLE on end; DROP to RECV on st (counts as a second drop only if the new TLP also overflows).
- Read side:
  - the RAM has a registered read; an internal 2-entry skid buffer prefetches so that rx_valid_out is continuous while rx_rdy_in is high;
  - sustained throughput is 1 beat per clock;
  - latency from end-beat commit to rx_valid_out is at most 4 cycles.
- Handshake: a beat transfers when rx_valid_out & rx_rdy_in. While rx_valid_out=1 and rx_rdy_in=0, all rx_*_out fields are held stable. rx_valid_out never deasserts without a transfer.
- Empty: read addr equals the commit pointer, so no read is issued. Pointers wrap modulo 2^ADDR_W.
- Simultaneous commit and read at the same address is legal; the write-before-read ordering is handled by the commit pointer update happening after the RAM write.

Test Plan:
- Defaults, 8-word TLP, st on w0, end on w7, rdy=1 → 2 beats; beat0 = {w0,w1,w2,w3} with st_out=1, lanes=3; beat1 = {w4..w7} with end_out=1, lanes=3; bar_hit/us_req match the st-word values on both beats.
- 6-word TLP → beat1 = {w4,w5,16'h0,16'h0}, lanes_out=1, end_out=1. Also a single-word TLP (st&end together) → one beat with st=end=1, lanes=0.
- rdy held 0 for 10 cycles mid-TLP → outputs stable throughout; after rdy=1 the beats come out in order with no loss or duplication.
- ADDR_W=3, rdy=0, send a 40-word TLP → tlp_drop pulses once, drop_cnt=1, no beats emitted. A following 4-word TLP is delivered intact.
- st with no end, then a new st → first TLP dropped (drop_cnt=1) and the second delivered. Then DROP_MALF=1 with malf on the end word → TLP dropped; with DROP_MALF=0 it is delivered with malf_out=1 on the end beat only.
- rst asserted mid-TLP with beats committed and pending → after the next edge valid_out=0 and drop_cnt=0; the next TLP is delivered correctly starting from address 0.

Source files
------------

// File: rtl/tlp_width_bridge_if.sv
// rtl/tlp_width_bridge_if.sv - Narrow receive / wide transmit TLP stream bundle
`timescale 1ns/1ps
interface tlp_width_bridge_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 64,
    parameter int BAR_W = 7,
    parameter int LW    = 2
);
    logic [IN_W-1:0]  rx_data_in;
    logic             rx_st_in;
    logic             rx_end_in;
    logic             rx_us_req_in;
    logic             rx_malf_tlp_in;
    logic [BAR_W-1:0] rx_bar_hit_in;

    logic [OUT_W-1:0] rx_data_out;
    logic             rx_valid_out;
    logic             rx_rdy_in;
    logic             rx_st_out;
    logic             rx_end_out;
    logic [LW-1:0]    rx_lanes_out;
    logic             rx_us_req_out;
    logic             rx_malf_tlp_out;
    logic [BAR_W-1:0] rx_bar_hit_out;

    modport master (
        output rx_data_in, rx_st_in, rx_end_in, rx_us_req_in, rx_malf_tlp_in, rx_bar_hit_in, rx_rdy_in,
        input  rx_data_out, rx_valid_out, rx_st_out, rx_end_out, rx_lanes_out,
               rx_us_req_out, rx_malf_tlp_out, rx_bar_hit_out
    );

    modport slave (
        input  rx_data_in, rx_st_in, rx_end_in, rx_us_req_in, rx_malf_tlp_in, rx_bar_hit_in, rx_rdy_in,
        output rx_data_out, rx_valid_out, rx_st_out, rx_end_out, rx_lanes_out,
               rx_us_req_out, rx_malf_tlp_out, rx_bar_hit_out
    );
endinterface

// File: rtl/tlp_width_bridge.sv
// rtl/tlp_width_bridge.sv - Store-and-forward TLP width bridge, IN_W words packed into OUT_W beats
`timescale 1ns/1ps
module tlp_width_bridge #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 64,
    parameter int ADDR_W    = 9,
    parameter int BAR_W     = 7,
    parameter int DROP_MALF = 0,
    parameter int LW        = ($clog2(OUT_W / IN_W) < 1) ? 1 : $clog2(OUT_W / IN_W)
) (
    input  logic                clk_125,
    input  logic                rst,
    tlp_width_bridge_if.slave   bus,
    output logic                tlp_drop,
    output logic [15:0]         drop_cnt
);
    localparam int                R         = OUT_W / IN_W;
    localparam logic [LW-1:0]     LANE_LAST = LW'(R - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             st;
        logic             en;
        logic [LW-1:0]    lanes;
        logic             us;
        logic             malf;
        logic [BAR_W-1:0] bar;
    } beat_t;

    typedef enum logic [1:0] {IDLE, RECV, DROP} wstate_e;

    wstate_e           state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     lane_q, lane_d, lane;
    logic [OUT_W-1:0]  pack_q, pack_d;
    logic              first_q, first_d, us_q, us_d;
    logic [BAR_W-1:0]  bar_q, bar_d;
    logic              tlp_drop_q, tlp_drop_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [16:0]       drop_sum;
    logic [1:0]        drop_inc;
    logic              start, wr_en;
    logic [ADDR_W-1:0] wr_addr, wr_nxt;
    beat_t             wr_beat;

    beat_t             mem_q [0:(1 << ADDR_W) - 1];
    beat_t             rdata_q, sk0_q, sk0_d, sk1_q, sk1_d;
    logic              rd_pend_q, pop, issue;
    logic [1:0]        cnt_q, cnt_d, occ;

    // Write side: a word is consumed in RECV, or whenever rx_st_in opens a new TLP.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        lane_d   = lane_q;
        pack_d   = pack_q;
        first_d  = first_q;
        us_d     = us_q;
        bar_d    = bar_q;
        start    = bus.rx_st_in;
        lane     = start ? '0 : lane_q;
        wr_en    = 1'b0;
        wr_addr  = start ? cm_ptr_q : wr_ptr_q;
        wr_nxt   = wr_addr + ADDR_ONE;
        drop_inc = 2'd0;
        wr_beat       = '0;
        wr_beat.data  = start ? '0 : pack_q;
        for (int i = 0; i < R; i++) begin
            if (lane == LW'(i)) wr_beat.data[OUT_W-1-i*IN_W -: IN_W] = bus.rx_data_in;
        end
        wr_beat.st    = start ? 1'b1 : first_q;
        wr_beat.en    = bus.rx_end_in;
        wr_beat.lanes = lane;
        wr_beat.us    = start ? bus.rx_us_req_in : us_q;
        wr_beat.malf  = bus.rx_end_in & bus.rx_malf_tlp_in;
        wr_beat.bar   = start ? bus.rx_bar_hit_in : bar_q;

        if ((state_q == RECV) || start) begin
            if ((state_q == RECV) && start) drop_inc = drop_inc + 2'd1;
            lane_d = lane + LW'(1);
            us_d   = wr_beat.us;
            bar_d  = wr_beat.bar;
            if ((lane == LANE_LAST) || bus.rx_end_in) begin
                pack_d  = '0;
                first_d = 1'b0;
                if (wr_nxt == rd_ptr_q) begin
                    drop_inc = drop_inc + 2'd1;
                    wr_ptr_d = cm_ptr_q;
                    state_d  = bus.rx_end_in ? IDLE : DROP;
                end else if ((DROP_MALF != 0) && bus.rx_end_in && bus.rx_malf_tlp_in) begin
                    drop_inc = drop_inc + 2'd1;
                    wr_ptr_d = cm_ptr_q;
                    state_d  = IDLE;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_nxt;
                    if (bus.rx_end_in) cm_ptr_d = wr_nxt;
                    state_d  = bus.rx_end_in ? IDLE : RECV;
                end
            end else begin
                wr_ptr_d = wr_addr;
                pack_d   = wr_beat.data;
                first_d  = wr_beat.st;
                state_d  = RECV;
            end
        end else if ((state_q == DROP) && bus.rx_end_in) begin
            state_d = IDLE;
        end

        tlp_drop_d = (drop_inc != 2'd0);
        drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Read side: keep (skid entries + read in flight) at most 2 so a full skid never overruns.
    always_comb begin
        pop      = (cnt_q != 2'd0) && bus.rx_rdy_in;
        occ      = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
        issue    = (rd_ptr_q != cm_ptr_q) && (occ < 2'd2);
        rd_ptr_d = issue ? rd_ptr_q + ADDR_ONE : rd_ptr_q;
        cnt_d    = occ;
        sk0_d    = pop ? sk1_q : sk0_q;
        sk1_d    = sk1_q;
        if (rd_pend_q) begin
            if (occ == 2'd1) sk0_d = rdata_q;
            else             sk1_d = rdata_q;
        end
    end

    always_ff @(posedge clk_125) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
            first_q    <= 1'b0;
            us_q       <= 1'b0;
            bar_q      <= '0;
            tlp_drop_q <= 1'b0;
            drop_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            cnt_q      <= '0;
            sk0_q      <= '0;
            sk1_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            first_q    <= first_d;
            us_q       <= us_d;
            bar_q      <= bar_d;
            tlp_drop_q <= tlp_drop_d;
            drop_cnt_q <= drop_cnt_d;
            rd_pend_q  <= issue;
            cnt_q      <= cnt_d;
            sk0_q      <= sk0_d;
            sk1_q      <= sk1_d;
        end
    end

    always_ff @(posedge clk_125) begin
        if (wr_en) mem_q[wr_addr] <= wr_beat;
        if (issue) rdata_q <= mem_q[rd_ptr_q];
    end

    assign bus.rx_valid_out    = (cnt_q != 2'd0);
    assign bus.rx_data_out     = sk0_q.data;
    assign bus.rx_st_out       = sk0_q.st;
    assign bus.rx_end_out      = sk0_q.en;
    assign bus.rx_lanes_out    = sk0_q.lanes;
    assign bus.rx_us_req_out   = sk0_q.us;
    assign bus.rx_malf_tlp_out = sk0_q.malf;
    assign bus.rx_bar_hit_out  = sk0_q.bar;
    assign tlp_drop            = tlp_drop_q;
    assign drop_cnt            = drop_cnt_q;
endmodule

// File: tb/tb_tlp_width_bridge.sv
// tb/tb_tlp_width_bridge.sv - Scoreboard bench for tlp_width_bridge, DROP_MALF=0 and DROP_MALF=1 side by side
`timescale 1ns/1ps
module tb_tlp_width_bridge;
    localparam int IN_W = 16, OUT_W = 64, ADDR_W = 3, BAR_W = 7, LW = 2;

    typedef struct packed {
        logic [63:0] data;
        logic        st;
        logic        en;
        logic [1:0]  lanes;
        logic        us;
        logic        malf;
        logic [6:0]  bar;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_in = '0;
    logic        st_in = 1'b0, end_in = 1'b0, us_in = 1'b0, malf_in = 1'b0, rdy = 1'b0;
    logic [6:0]  bar_in = '0;
    logic        drop0, drop1;
    logic [15:0] cnt0, cnt1;

    int    errors = 0, checks = 0;
    int    pulses0 = 0, pulses1 = 0;
    beat_t q0[$], q1[$];
    logic  prev_v[2], prev_r[2];
    beat_t prev_b[2];

    always #4 clk = ~clk;

    tlp_width_bridge_if #(.IN_W(IN_W), .OUT_W(OUT_W), .BAR_W(BAR_W), .LW(LW)) bus0 ();
    tlp_width_bridge_if #(.IN_W(IN_W), .OUT_W(OUT_W), .BAR_W(BAR_W), .LW(LW)) bus1 ();

    assign bus0.rx_data_in = d_in;     assign bus1.rx_data_in = d_in;
    assign bus0.rx_st_in = st_in;      assign bus1.rx_st_in = st_in;
    assign bus0.rx_end_in = end_in;    assign bus1.rx_end_in = end_in;
    assign bus0.rx_us_req_in = us_in;  assign bus1.rx_us_req_in = us_in;
    assign bus0.rx_malf_tlp_in = malf_in; assign bus1.rx_malf_tlp_in = malf_in;
    assign bus0.rx_bar_hit_in = bar_in; assign bus1.rx_bar_hit_in = bar_in;
    assign bus0.rx_rdy_in = rdy;       assign bus1.rx_rdy_in = rdy;

    tlp_width_bridge #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .BAR_W(BAR_W), .DROP_MALF(0), .LW(LW)) u0 (
        .clk_125(clk), .rst(rst), .bus(bus0), .tlp_drop(drop0), .drop_cnt(cnt0));
    tlp_width_bridge #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .BAR_W(BAR_W), .DROP_MALF(1), .LW(LW)) u1 (
        .clk_125(clk), .rst(rst), .bus(bus1), .tlp_drop(drop1), .drop_cnt(cnt1));

    function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    function automatic void mon(input int d, input logic v, input beat_t b);
        beat_t e;
        if (prev_v[d] && !prev_r[d]) check($sformatf("hold dut%0d", d), {v, b}, {1'b1, prev_b[d]});
        if (v && rdy) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected beat dut%0d: got %h, expected none", d, b);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("beat dut%0d", d), b, e);
            end
        end
        prev_v[d] = v;
        prev_r[d] = rdy;
        prev_b[d] = b;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_v[0] = 1'b0;
            prev_v[1] = 1'b0;
        end else begin
            mon(0, bus0.rx_valid_out, {bus0.rx_data_out, bus0.rx_st_out, bus0.rx_end_out, bus0.rx_lanes_out,
                                       bus0.rx_us_req_out, bus0.rx_malf_tlp_out, bus0.rx_bar_hit_out});
            mon(1, bus1.rx_valid_out, {bus1.rx_data_out, bus1.rx_st_out, bus1.rx_end_out, bus1.rx_lanes_out,
                                       bus1.rx_us_req_out, bus1.rx_malf_tlp_out, bus1.rx_bar_hit_out});
            if (drop0) pulses0++;
            if (drop1) pulses1++;
        end
    end

    task automatic word(input logic [15:0] d, input logic s, input logic e, input logic u,
                        input logic m, input logic [6:0] b);
        d_in = d; st_in = s; end_in = e; us_in = u; malf_in = m; bar_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) word(16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b1, 7'h55);
    endtask

    // Non-st words carry inverted us/bar and non-end words carry malf=1, so mis-sampling shows up.
    task automatic send(input int n, input logic [15:0] base, input logic [6:0] bar, input logic us,
                        input logic malf, input logic has_end);
        for (int k = 0; k < n; k++) begin
            logic last;
            last = has_end && (k == n - 1);
            word(base + 16'(k), k == 0, last, (k == 0) ? us : ~us, last ? malf : 1'b1, (k == 0) ? bar : ~bar);
        end
    endtask

    task automatic expect_beat(input int mask, input logic [63:0] data, input logic s, input logic e,
                               input logic [1:0] lanes, input logic u, input logic m, input logic [6:0] bar);
        beat_t b;
        b = {data, s, e, lanes, u, m, bar};
        if (mask[0]) q0.push_back(b);
        if (mask[1]) q1.push_back(b);
    endtask

    task automatic expect_tlp(input int mask, input int n, input logic [15:0] base, input logic [6:0] bar,
                              input logic us, input logic malf);
        int nb;
        nb = (n + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            logic [63:0] data;
            logic        last;
            data = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * b + l < n) data[63-16*l -: 16] = base + 16'(4 * b + l);
            end
            last = (b == nb - 1);
            expect_beat(mask, data, b == 0, last, last ? 2'(n - 1 - 4 * b) : 2'd3, us, last & malf, bar);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
            idle(1);
            t++;
        end
        idle(3);
        check({name, " pending beats"}, q0.size() + q1.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst valid0", bus0.rx_valid_out, 1'b0);
        check("rst valid1", bus1.rx_valid_out, 1'b0);
        check("rst data0", bus0.rx_data_out, 64'h0);
        check("rst drop_cnt0", cnt0, 16'h0);
        check("rst drop_cnt1", cnt1, 16'h0);
        check("rst tlp_drop0", drop0, 1'b0);
        rst = 1'b0;
        rdy = 1'b1;
        idle(2);

        expect_beat(3, 64'h1000_1001_1002_1003, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 7'h05);
        expect_beat(3, 64'h1004_1005_1006_1007, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 7'h05);
        send(8, 16'h1000, 7'h05, 1'b1, 1'b0, 1'b1);
        idle(3);
        expect_beat(3, 64'h2000_2001_2002_2003, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 7'h12);
        expect_beat(3, 64'h2004_2005_0000_0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 7'h12);
        send(6, 16'h2000, 7'h12, 1'b0, 1'b0, 1'b1);
        idle(2);
        expect_beat(3, 64'hABCD_0000_0000_0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 7'h7F);
        send(1, 16'hABCD, 7'h7F, 1'b1, 1'b0, 1'b1);
        drain("basic");

        rdy = 1'b0;
        expect_tlp(3, 12, 16'h3000, 7'h21, 1'b0, 1'b0);
        send(12, 16'h3000, 7'h21, 1'b0, 1'b0, 1'b1);
        idle(10);
        rdy = 1'b1;
        drain("backpressure");

        rdy = 1'b0;
        idle(2);
        send(40, 16'h4000, 7'h33, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("ovf drop_cnt0", cnt0, 16'd1);
        check("ovf drop_cnt1", cnt1, 16'd1);
        check("ovf no beat0", bus0.rx_valid_out, 1'b0);
        expect_tlp(3, 4, 16'h4100, 7'h44, 1'b0, 1'b0);
        send(4, 16'h4100, 7'h44, 1'b0, 1'b0, 1'b1);
        idle(4);
        rdy = 1'b1;
        drain("overflow");

        expect_tlp(3, 5, 16'h5100, 7'h0A, 1'b1, 1'b0);
        send(6, 16'h5000, 7'h09, 1'b0, 1'b0, 1'b0);
        send(5, 16'h5100, 7'h0A, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("abort drop_cnt0", cnt0, 16'd2);
        check("abort drop_cnt1", cnt1, 16'd2);
        drain("abort");

        expect_tlp(1, 5, 16'h6000, 7'h3C, 1'b1, 1'b1);
        send(5, 16'h6000, 7'h3C, 1'b1, 1'b1, 1'b1);
        idle(3);
        check("malf drop_cnt0", cnt0, 16'd2);
        check("malf drop_cnt1", cnt1, 16'd3);
        drain("malf");

        rdy = 1'b0;
        send(8, 16'h7000, 7'h11, 1'b0, 1'b0, 1'b1);
        send(3, 16'h7100, 7'h11, 1'b0, 1'b0, 1'b0);
        check("pending before rst", bus0.rx_valid_out, 1'b1);
        rst = 1'b1;
        idle(1);
        check("mid rst valid0", bus0.rx_valid_out, 1'b0);
        check("mid rst valid1", bus1.rx_valid_out, 1'b0);
        check("mid rst drop_cnt0", cnt0, 16'h0);
        check("mid rst drop_cnt1", cnt1, 16'h0);
        rst = 1'b0;
        rdy = 1'b1;
        idle(2);
        expect_tlp(3, 4, 16'h8000, 7'h66, 1'b1, 1'b0);
        send(4, 16'h8000, 7'h66, 1'b1, 1'b0, 1'b1);
        drain("post-reset");

        check("drop pulses0", pulses0, 2);
        check("drop pulses1", pulses1, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
